// File: rtl/gray_mem_arbiter_if.sv
// gray_mem_arbiter_if
// Bundles the shared gray-image read port and the two requester ports.
//   mem_ready, mem_req, mem_addr, mem_data : memory side (1-cycle read latency)
//   req0/1, addr0/1, gnt0/1                : requester address handshake
//   rvalid0/1, rdata0/1                    : per-port return data
//   busy                                   : arbiter owned or reads in flight
// Modport slave is the arbiter's view; master is the environment's view.
interface gray_mem_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  logic          mem_ready;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          busy;

  modport slave (
    input  mem_ready, mem_data, req0, req1, addr0, addr1,
    output mem_req, mem_addr, gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy
  );

  modport master (
    output mem_ready, mem_data, req0, req1, addr0, addr1,
    input  mem_req, mem_addr, gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy
  );
endinterface

// File: rtl/gray_mem_arbiter.sv
// gray_mem_arbiter
// Shares the single gray-image memory read port between two pixel-fetch
// requesters. Round-robin with bounded ownership: an owner keeps the port
// for up to HOLD back-to-back grants, then yields if the other port waits.
// Grants are combinational; read data returns to the granting port exactly
// three cycles after the grant through a two-stage {valid,id} tag pipe.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : gray_mem_arbiter_if.slave (memory port, requester ports, busy)
module gray_mem_arbiter #(
  parameter int AW   = 14,
  parameter int DW   = 8,
  parameter int HOLD = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  gray_mem_arbiter_if.slave    bus
);

  localparam logic [3:0] HOLD_C = 4'(HOLD);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_OWN0 = 2'd2,
    ST_OWN1 = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          last;
  logic          ready_q;

  logic          gnt0_p0, gnt1_p0;
  logic          vld_p0;
  logic          id_p0;
  logic          vld_p1, id_p1;
  logic          mem_req_p1;
  logic [AW-1:0] mem_addr_p1;
  logic          vld_p2, id_p2;
  logic          rvalid0_p3, rvalid1_p3;
  logic [DW-1:0] rdata0_p3, rdata1_p3;

  // Grant counter saturates at HOLD; a saturated owner with no competitor
  // keeps being granted without the count moving.
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= HOLD_C) ? HOLD_C : c + 4'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_INIT;
      cnt     <= 4'd0;
      last    <= 1'b1;   // port 0 wins the first tie
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready_q <= ready_q | bus.mem_ready;  // sticky until reset
      if (vld_p0) last <= id_p0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt0_p0   = 1'b0;
    gnt1_p0   = 1'b0;
    case (state)
      ST_INIT: begin
        if (ready_q) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        // On a tie the port not granted most recently wins.
        if (bus.req0 && (!bus.req1 || last)) begin
          gnt0_p0   = 1'b1;
          state_nxt = ST_OWN0;
          cnt_nxt   = 4'd1;
        end else if (bus.req1) begin
          gnt1_p0   = 1'b1;
          state_nxt = ST_OWN1;
          cnt_nxt   = 4'd1;
        end
      end
      ST_OWN0: begin
        // Owner continues unless it has used its HOLD grants and port 1 waits.
        if (bus.req0 && !(cnt == HOLD_C && bus.req1)) begin
          gnt0_p0 = 1'b1;
          cnt_nxt = sat_inc(cnt);
        end else if (bus.req1) begin
          gnt1_p0   = 1'b1;
          state_nxt = ST_OWN1;
          cnt_nxt   = 4'd1;
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 4'd0;
        end
      end
      ST_OWN1: begin
        if (bus.req1 && !(cnt == HOLD_C && bus.req0)) begin
          gnt1_p0 = 1'b1;
          cnt_nxt = sat_inc(cnt);
        end else if (bus.req0) begin
          gnt0_p0   = 1'b1;
          state_nxt = ST_OWN0;
          cnt_nxt   = 4'd1;
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 4'd0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign vld_p0 = gnt0_p0 | gnt1_p0;
  assign id_p0  = gnt1_p0;

  // Stage p1: memory read issue and tag capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_p1  <= 1'b0;
      mem_addr_p1 <= '0;
      vld_p1      <= 1'b0;
      id_p1       <= 1'b0;
    end else begin
      mem_req_p1 <= vld_p0;
      vld_p1     <= vld_p0;
      if (vld_p0) begin
        id_p1       <= id_p0;
        mem_addr_p1 <= id_p0 ? bus.addr1 : bus.addr0;
      end
    end
  end

  // Stage p2: tag waits while the memory produces data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      id_p2  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      id_p2  <= id_p1;
    end
  end

  // Stage p3: route returned pixel to the tagged port; other port holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid0_p3 <= 1'b0;
      rvalid1_p3 <= 1'b0;
      rdata0_p3  <= '0;
      rdata1_p3  <= '0;
    end else begin
      rvalid0_p3 <= vld_p2 && !id_p2;
      rvalid1_p3 <= vld_p2 &&  id_p2;
      if (vld_p2 && !id_p2) rdata0_p3 <= bus.mem_data;
      if (vld_p2 &&  id_p2) rdata1_p3 <= bus.mem_data;
    end
  end

  assign bus.gnt0     = gnt0_p0;
  assign bus.gnt1     = gnt1_p0;
  assign bus.mem_req  = mem_req_p1;
  assign bus.mem_addr = mem_addr_p1;
  assign bus.rvalid0  = rvalid0_p3;
  assign bus.rvalid1  = rvalid1_p3;
  assign bus.rdata0   = rdata0_p3;
  assign bus.rdata1   = rdata1_p3;
  // Busy covers ownership plus every tag still in the pipe, including the
  // cycle its rvalid is presented.
  assign bus.busy     = (state == ST_OWN0) || (state == ST_OWN1) ||
                        vld_p1 || vld_p2 || rvalid0_p3 || rvalid1_p3;

endmodule

// File: tb/tb_gray_mem_arbiter.sv
// tb_gray_mem_arbiter
// Directed stimulus for gray_mem_arbiter with a cycle-level behavioural
// model (owner / run-length / grant history) checked on every falling edge,
// plus literal expectations at the key points of each scenario.
module tb_gray_mem_arbiter;

  localparam int AW   = 14;
  localparam int DW   = 8;
  localparam int HOLD = 9;

  logic clk = 1'b0;
  logic reset;

  gray_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  gray_mem_arbiter #(.AW(AW), .DW(DW), .HOLD(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Image content: distinct per address, easy to compute by hand.
  function automatic logic [7:0] pix(input logic [13:0] a);
    return a[7:0] ^ {1'b0, a[13:7]} ^ 8'h3C;
  endfunction

  // Memory: one-cycle registered read.
  always @(posedge clk) begin
    if (bus.mem_req) bus.mem_data <= pix(bus.mem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          since, first_ready, owner, run, last_g, g;
  int          gh1, gh2, gh3;
  logic [13:0] ah1, ah2, ah3;
  logic [13:0] exp_addr;
  logic [7:0]  exp_rd0, exp_rd1;
  logic        r0, r1, allowed, exp_busy;

  task automatic model_clear();
    since = 0; first_ready = -1; owner = -1; run = 0; last_g = 1;
    gh1 = -1; gh2 = -1; gh3 = -1; ah1 = '0; ah2 = '0; ah3 = '0;
    exp_addr = '0; exp_rd0 = '0; exp_rd1 = '0;
  endtask

  initial model_clear();

  always @(negedge clk) begin
    if (reset) begin
      model_clear();
      chk("m_rst_gnt0", bus.gnt0, 0);
      chk("m_rst_gnt1", bus.gnt1, 0);
      chk("m_rst_mem_req", bus.mem_req, 0);
      chk("m_rst_mem_addr", bus.mem_addr, 0);
      chk("m_rst_rvalid", {bus.rvalid1, bus.rvalid0}, 0);
      chk("m_rst_rdata", {bus.rdata1, bus.rdata0}, 0);
      chk("m_rst_busy", bus.busy, 0);
    end else begin
      r0 = bus.req0;
      r1 = bus.req1;
      // Grants open two cycles after mem_ready is first seen.
      allowed = (first_ready >= 0) && (since >= first_ready + 2);
      if (bus.mem_ready && first_ready < 0) first_ready = since;
      g = -1;
      if (allowed) begin
        if (owner < 0) begin
          if (r0 && r1)  g = 1 - last_g;
          else if (r0)   g = 0;
          else if (r1)   g = 1;
        end else begin
          logic ro, ry;
          ro = (owner == 0) ? r0 : r1;
          ry = (owner == 0) ? r1 : r0;
          if (ro && !(run >= HOLD && ry)) g = owner;
          else if (ry)                    g = 1 - owner;
        end
      end
      if (gh3 == 0) exp_rd0 = pix(ah3);
      if (gh3 == 1) exp_rd1 = pix(ah3);
      exp_busy = (owner >= 0) || (gh1 >= 0) || (gh2 >= 0) || (gh3 >= 0);

      chk("m_gnt0", bus.gnt0, (g == 0));
      chk("m_gnt1", bus.gnt1, (g == 1));
      chk("m_mem_req", bus.mem_req, (gh1 >= 0));
      chk("m_mem_addr", bus.mem_addr, exp_addr);
      chk("m_rvalid0", bus.rvalid0, (gh3 == 0));
      chk("m_rvalid1", bus.rvalid1, (gh3 == 1));
      chk("m_rdata0", bus.rdata0, exp_rd0);
      chk("m_rdata1", bus.rdata1, exp_rd1);
      chk("m_busy", bus.busy, exp_busy);

      // advance to next cycle
      gh3 = gh2; ah3 = ah2;
      gh2 = gh1; ah2 = ah1;
      gh1 = g;
      if (g >= 0) begin
        ah1 = (g == 0) ? bus.addr0 : bus.addr1;
        exp_addr = ah1;
        if (g == owner) run++;
        else begin owner = g; run = 1; end
        last_g = g;
      end else begin
        owner = -1;
        run = 0;
      end
      since++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic g0s, g1s;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = '0;  bus.addr1 = '0;
    repeat (3) cyc();
    #1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rvalid0", bus.rvalid0, 0);
    cyc();

    // INIT: requests ignored until memory ready
    reset = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 14'h0081;
    for (int i = 0; i < 5; i++) begin
      #1 chk("init_no_gnt", bus.gnt0, 0);
      chk("init_no_mem_req", bus.mem_req, 0);
      cyc();
    end
    bus.mem_ready = 1'b1;
    #1 chk("rdy_c0", bus.gnt0, 0);
    cyc();
    #1 chk("rdy_c1", bus.gnt0, 0);
    cyc();
    #1 chk("rdy_gnt0", bus.gnt0, 1);
    cyc();
    bus.req0 = 1'b0;
    cyc();
    cyc();
    #1 chk("rdy_rvalid0", bus.rvalid0, 1);
    chk("rdy_rdata0", bus.rdata0, 8'hBC);
    cyc();

    // Single-port burst, one grant per cycle
    for (int i = 0; i < 20; i++) begin
      bus.req0 = 1'b1; bus.addr0 = 14'(i);
      #1 chk("burst_gnt0", bus.gnt0, 1);
      if (i >= 3) begin
        chk("burst_rvalid0", bus.rvalid0, 1);
        chk("burst_rdata0", bus.rdata0, (i - 3) ^ 8'h3C);
      end
      cyc();
    end
    bus.req0 = 1'b0;
    repeat (5) cyc();

    // Tie after reset, then HOLD fairness with both ports requesting
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    cyc(); cyc();
    bus.req0 = 1'b1; bus.addr0 = 14'h0100;
    bus.req1 = 1'b1; bus.addr1 = 14'h1000;
    for (int k = 0; k < 27; k++) begin
      #1 g0s = bus.gnt0; g1s = bus.gnt1;
      chk("fair_pattern", {30'd0, g1s, g0s}, ((k / 9) % 2 == 0) ? 2'b01 : 2'b10);
      cyc();
      if (g0s) bus.addr0 = bus.addr0 + 14'd1;
      if (g1s) bus.addr1 = bus.addr1 + 14'd1;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (5) cyc();

    // Port 1 owner drops after three grants while port 0 waits
    bus.req1 = 1'b1; bus.addr1 = 14'h2000;
    #1 chk("drop_g1_a", bus.gnt1, 1);
    cyc();
    bus.req0 = 1'b1; bus.addr0 = 14'h0200; bus.addr1 = 14'h2001;
    #1 chk("drop_g1_b", bus.gnt1, 1);
    cyc();
    bus.addr1 = 14'h2002;
    #1 chk("drop_g1_c", bus.gnt1, 1);
    cyc();
    bus.req1 = 1'b0;
    #1 chk("drop_gnt0", bus.gnt0, 1);
    cyc();
    bus.req1 = 1'b1; bus.addr1 = 14'h2003; bus.addr0 = 14'h0201;
    for (int j = 0; j < 8; j++) begin
      #1 chk("drop_run_gnt0", bus.gnt0, 1);
      cyc();
      bus.addr0 = bus.addr0 + 14'd1;
    end
    #1 chk("drop_yield_gnt1", bus.gnt1, 1);
    cyc();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (5) cyc();

    // Reset with two reads in flight
    bus.req0 = 1'b1; bus.addr0 = 14'h0300;
    cyc();
    bus.addr0 = 14'h0301;
    cyc();
    reset = 1'b1; bus.req0 = 1'b0;
    cyc(); cyc();
    reset = 1'b0; bus.mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1 chk("mid_rst_rvalid", {bus.rvalid1, bus.rvalid0}, 0);
      chk("mid_rst_busy", bus.busy, 0);
      cyc();
    end
    bus.req0 = 1'b1; bus.addr0 = 14'h0302;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mid_rst_init_no_gnt", bus.gnt0, 0);
      cyc();
    end
    bus.req0 = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
